// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 LCD sequencer: bus addresses, FSM
// states, the queued-entry layout and the power-on init command ROM.
package lcd_pkg;

    localparam logic [31:0] LCD_DATA_ADDR = 32'h0000_F000;
    localparam logic [31:0] LCD_CMD_ADDR  = 32'h0000_F001;
    localparam logic [31:0] LCD_STAT_ADDR = 32'h0000_F002;

    typedef enum logic [2:0] {
        ST_INIT_WAIT = 3'd0,
        ST_INIT_LOAD = 3'd1,
        ST_IDLE      = 3'd2,
        ST_SETUP     = 3'd3,
        ST_PULSE     = 3'd4,
        ST_HOLD      = 3'd5,
        ST_WAIT      = 3'd6
    } lcd_state_t;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } lcd_entry_t;

    // Function set 8-bit/2-line, display on, entry mode increment, clear.
    localparam int unsigned INIT_LEN = 4;
    localparam logic [3:0][7:0] INIT_ROM = {8'h01, 8'h06, 8'h0C, 8'h38};

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Clear display (0x01) and return home (0x02/0x03) need the long wait.
    function automatic logic is_long_cmd(input lcd_entry_t e);
        return !e.rs && (e.data[7:2] == 6'b0);
    endfunction

endpackage

// File: rtl/lcd_fifo.sv
// Small synchronous FIFO holding pending LCD writes. Head entry is visible
// on pop_data without a read latency; pushes while full are dropped.
module lcd_fifo
    import lcd_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  lcd_entry_t                 push_data,
    input  logic                       pop,
    output lcd_entry_t                 pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);

    lcd_entry_t       mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             push_ok;
    logic             pop_ok;

    // Acceptance is judged on the pre-pop occupancy, so a full FIFO drops a
    // push even when the same cycle pops.
    assign full    = (cnt == (AW + 1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage array, written at the tail.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally; occupancy tracks push/pop balance.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/lcd_sequencer.sv
// Memory-mapped HD44780 controller. CPU character/command writes are queued
// and replayed as timed RS/E/DATA cycles; the power-on init sequence runs
// first after every reset.
module lcd_sequencer
    import lcd_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned T_SETUP    = 2,
    parameter int unsigned T_PULSE    = 12,
    parameter int unsigned T_HOLD     = 2,
    parameter int unsigned T_SHORT    = 2000,
    parameter int unsigned T_LONG     = 82000,
    parameter int unsigned T_POWERUP  = 750000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [15:0] write,
    input  logic        we,
    input  logic        re,
    output logic [15:0] read,
    output logic [10:0] lcdPins,
    output logic        busy
);

    localparam int unsigned CNT_MAX = max2(max2(max2(T_SETUP, T_PULSE), max2(T_HOLD, T_SHORT)),
                                           max2(T_LONG, T_POWERUP));
    localparam int unsigned CW = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] SETUP_LD     = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] PULSE_LD     = CW'(T_PULSE - 1);
    localparam logic [CW-1:0] HOLD_LD      = CW'(T_HOLD - 1);
    localparam logic [CW-1:0] SHORT_LD     = CW'(T_SHORT - 1);
    localparam logic [CW-1:0] LONG_LD      = CW'(T_LONG - 1);
    localparam logic [CW-1:0] POWERUP_LAST = CW'(T_POWERUP - 1);

    lcd_state_t                    state;
    logic [CW-1:0]                 cnt;
    lcd_entry_t                    cur;
    logic [2:0]                    init_idx;
    logic                          init_done;
    logic                          overflow;

    logic                          sel_data;
    logic                          sel_cmd;
    logic                          sel_stat;
    logic                          push;
    lcd_entry_t                    push_entry;
    logic                          pop;
    lcd_entry_t                    fifo_head;
    logic                          fifo_full;
    logic                          fifo_empty;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic                          unused_bits;

    assign sel_data   = we && (addr == LCD_DATA_ADDR);
    assign sel_cmd    = we && (addr == LCD_CMD_ADDR);
    assign sel_stat   = we && (addr == LCD_STAT_ADDR);
    assign push       = sel_data || sel_cmd;
    assign push_entry = '{rs: sel_data, data: write[7:0]};
    assign pop        = (state == ST_IDLE) && !fifo_empty;

    // re carries no side effects here; reads decode purely from addr.
    assign unused_bits = &{1'b0, re, write[15:8]};

    lcd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Sticky overflow: set by a dropped push, cleared by a status write.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (sel_stat) begin
            overflow <= 1'b0;
        end else if (push && fifo_full) begin
            overflow <= 1'b1;
        end
    end

    // Bus cycle sequencer. Timed states load cnt with N-1 on entry and exit
    // at zero. INIT_WAIT is entered from reset with cnt at 0, so it counts
    // up to T_POWERUP-1 instead; every other state counts down.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_INIT_WAIT;
            cnt       <= '0;
            cur       <= '0;
            init_idx  <= '0;
            init_done <= 1'b0;
        end else begin
            case (state)
                ST_INIT_WAIT: begin
                    if (cnt == POWERUP_LAST) begin
                        state <= ST_INIT_LOAD;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_INIT_LOAD: begin
                    cur      <= '{rs: 1'b0, data: INIT_ROM[init_idx[1:0]]};
                    init_idx <= init_idx + 1'b1;
                    state    <= ST_SETUP;
                    cnt      <= SETUP_LD;
                end
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        cur   <= fifo_head;
                        state <= ST_SETUP;
                        cnt   <= SETUP_LD;
                    end
                end
                ST_SETUP: begin
                    if (cnt == '0) begin
                        state <= ST_PULSE;
                        cnt   <= PULSE_LD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_PULSE: begin
                    if (cnt == '0) begin
                        state <= ST_HOLD;
                        cnt   <= HOLD_LD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (cnt == '0) begin
                        state <= ST_WAIT;
                        cnt   <= is_long_cmd(cur) ? LONG_LD : SHORT_LD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
                        if (init_done) begin
                            state <= ST_IDLE;
                        end else if (init_idx == 3'(INIT_LEN)) begin
                            init_done <= 1'b1;
                            state     <= ST_IDLE;
                        end else begin
                            state <= ST_INIT_LOAD;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign lcdPins = {(state == ST_PULSE), 1'b0, cur.rs, cur.data};
    assign busy    = (state != ST_IDLE) || (fifo_count != '0) || !init_done;
    assign read    = (addr == LCD_STAT_ADDR) ? {13'b0, overflow, fifo_full, busy} : '0;

endmodule

// File: tb/tb_lcd_sequencer.sv
// Directed bench for lcd_sequencer with shortened timing parameters.
module tb_lcd_sequencer;

    localparam logic [31:0] A_DATA = 32'h0000_F000;
    localparam logic [31:0] A_CMD  = 32'h0000_F001;
    localparam logic [31:0] A_STAT = 32'h0000_F002;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic [15:0] wr_data;
    logic        we;
    logic        re;
    logic [15:0] rd;
    logic [10:0] pins;
    logic        busy;

    int tests_run;
    int tests_failed;

    // Pin monitor state, sampled on the falling edge.
    int          cyc;
    logic        e_prev;
    logic        busy_prev;
    logic [8:0]  prev9;
    logic [8:0]  rise_q[$];
    logic [8:0]  pre_q[$];
    logic [8:0]  hold_q[$];
    int          rise_cyc[$];
    int          fall_cyc[$];
    int          busy_fall_cyc;
    int          glitch_cnt;

    lcd_sequencer #(
        .FIFO_DEPTH (4),
        .T_SETUP    (1),
        .T_PULSE    (3),
        .T_HOLD     (1),
        .T_SHORT    (5),
        .T_LONG     (20),
        .T_POWERUP  (10)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .addr    (addr),
        .write   (wr_data),
        .we      (we),
        .re      (re),
        .read    (rd),
        .lcdPins (pins),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Record E edges, RS/DATA around each pulse, and busy falling.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (pins[10] && !e_prev) begin
            rise_q.push_back(pins[8:0]);
            pre_q.push_back(prev9);
            rise_cyc.push_back(cyc);
        end
        if (pins[10] && e_prev && (pins[8:0] != prev9)) glitch_cnt = glitch_cnt + 1;
        if (!pins[10] && e_prev) begin
            fall_cyc.push_back(cyc);
            hold_q.push_back(pins[8:0]);
        end
        if (!busy && busy_prev) busy_fall_cyc = cyc;
        e_prev    = pins[10];
        busy_prev = busy;
        prev9     = pins[8:0];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        rise_q.delete();
        pre_q.delete();
        hold_q.delete();
        rise_cyc.delete();
        fall_cyc.delete();
        glitch_cnt    = 0;
        busy_fall_cyc = -1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [15:0] d);
        addr    = a;
        wr_data = d;
        we      = 1'b1;
        tick();
        we      = 1'b0;
        addr    = '0;
        wr_data = '0;
    endtask

    // Waits for busy low within a cycle budget, then lets the monitor catch up.
    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_idle_timeout: busy=%b after %0d cycles, required 0", name, busy, n);
        end
        tick();
    endtask

    task automatic test_reset();
        logic [8:0] exp_init [4];
        int n;
        exp_init = '{9'h038, 9'h00C, 9'h006, 9'h001};
        rst = 1'b1;
        tick();
        tests_run++;
        if (pins !== 11'h000) begin
            tests_failed++;
            $display("FAIL reset_pins: got %h, required 000", pins);
        end
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_busy: got %b, required 1", busy);
        end
        addr = A_STAT;
        #1;
        tests_run++;
        if (rd !== 16'h0001) begin
            tests_failed++;
            $display("FAIL reset_status: got %h, required 0001", rd);
        end
        addr = '0;
        rst  = 1'b0;
        tick();
        clear_mon();
        // Counted from the first edge that sees rst low.
        n = 0;
        while (!pins[10] && n < 50) begin
            tick();
            n++;
        end
        tests_run++;
        if (n !== 11) begin
            tests_failed++;
            $display("FAIL init_first_e: E rose after %0d cycles, required 11", n);
        end
        tests_run++;
        if (pins[8:0] !== 9'h038) begin
            tests_failed++;
            $display("FAIL init_first_byte: got %h, required 038", pins[8:0]);
        end
        wait_idle(400, "init");
        tests_run++;
        if (rise_q.size() !== 4 || fall_cyc.size() !== 4) begin
            tests_failed++;
            $display("FAIL init_count: rises=%0d falls=%0d, required 4", rise_q.size(), fall_cyc.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests_run++;
                if (rise_q[i] !== exp_init[i]) begin
                    tests_failed++;
                    $display("FAIL init_byte%0d: got %h, required %h", i, rise_q[i], exp_init[i]);
                end
            end
            // HOLD (1) plus the 20-cycle clear wait.
            tests_run++;
            if (busy_fall_cyc - fall_cyc[3] !== 21) begin
                tests_failed++;
                $display("FAIL init_clear_wait: %0d cycles, required 21", busy_fall_cyc - fall_cyc[3]);
            end
        end
    endtask

    task automatic test_char();
        int n;
        clear_mon();
        bus_write(A_DATA, 16'h0041);
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        tests_run++;
        if (n !== 11) begin
            tests_failed++;
            $display("FAIL char_period: busy low after %0d cycles, required 11", n);
        end
        tick();
        tests_run++;
        if (rise_q.size() !== 1 || fall_cyc.size() !== 1) begin
            tests_failed++;
            $display("FAIL char_count: rises=%0d falls=%0d, required 1", rise_q.size(), fall_cyc.size());
        end else begin
            tests_run++;
            if (rise_q[0] !== 9'h141) begin
                tests_failed++;
                $display("FAIL char_pulse_data: got %h, required 141", rise_q[0]);
            end
            tests_run++;
            if (pre_q[0] !== 9'h141) begin
                tests_failed++;
                $display("FAIL char_setup_data: got %h, required 141", pre_q[0]);
            end
            tests_run++;
            if (hold_q[0] !== 9'h141) begin
                tests_failed++;
                $display("FAIL char_hold_data: got %h, required 141", hold_q[0]);
            end
            tests_run++;
            if (fall_cyc[0] - rise_cyc[0] !== 3) begin
                tests_failed++;
                $display("FAIL char_e_width: %0d cycles, required 3", fall_cyc[0] - rise_cyc[0]);
            end
        end
        tests_run++;
        if (glitch_cnt !== 0) begin
            tests_failed++;
            $display("FAIL char_glitch: %0d changes while E high, required 0", glitch_cnt);
        end
    endtask

    task automatic test_long_cmd();
        clear_mon();
        bus_write(A_CMD, 16'h0001);
        bus_write(A_DATA, 16'h0042);
        wait_idle(200, "long_cmd");
        tests_run++;
        if (rise_q.size() !== 2 || fall_cyc.size() !== 2) begin
            tests_failed++;
            $display("FAIL long_count: rises=%0d falls=%0d, required 2", rise_q.size(), fall_cyc.size());
        end else begin
            tests_run++;
            if (rise_q[0] !== 9'h001 || rise_q[1] !== 9'h142) begin
                tests_failed++;
                $display("FAIL long_bytes: got %h %h, required 001 142", rise_q[0], rise_q[1]);
            end
            // HOLD 1 + WAIT 20 + IDLE pop 1 + SETUP 1 before E rises again.
            tests_run++;
            if (rise_cyc[1] - fall_cyc[0] !== 23) begin
                tests_failed++;
                $display("FAIL long_gap: %0d cycles, required 23", rise_cyc[1] - fall_cyc[0]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [8:0] exp [8];
        exp = '{9'h038, 9'h00C, 9'h006, 9'h001, 9'h161, 9'h162, 9'h163, 9'h164};
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        clear_mon();
        for (int i = 0; i < 5; i++) bus_write(A_DATA, 16'(16'h0061 + i));
        addr = A_STAT;
        re   = 1'b1;
        #1;
        tests_run++;
        if (rd !== 16'h0007) begin
            tests_failed++;
            $display("FAIL ovf_status: got %h, required 0007", rd);
        end
        re   = 1'b0;
        addr = '0;
        wait_idle(600, "ovf");
        tests_run++;
        if (rise_q.size() !== 8) begin
            tests_failed++;
            $display("FAIL ovf_count: rises=%0d, required 8", rise_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                tests_run++;
                if (rise_q[i] !== exp[i]) begin
                    tests_failed++;
                    $display("FAIL ovf_byte%0d: got %h, required %h", i, rise_q[i], exp[i]);
                end
            end
        end
        addr = A_STAT;
        #1;
        tests_run++;
        if (rd !== 16'h0004) begin
            tests_failed++;
            $display("FAIL ovf_sticky: got %h, required 0004", rd);
        end
        bus_write(A_STAT, 16'hFFFF);
        addr = A_STAT;
        #1;
        tests_run++;
        if (rd !== 16'h0000) begin
            tests_failed++;
            $display("FAIL ovf_clear: got %h, required 0000", rd);
        end
        addr = '0;
    endtask

    task automatic test_reset_mid();
        int n;
        bus_write(A_DATA, 16'h0055);
        bus_write(A_DATA, 16'h0056);
        n = 0;
        while (!pins[10] && n < 50) begin
            tick();
            n++;
        end
        tests_run++;
        if (pins[10] !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_e_timeout: E=%b, required 1", pins[10]);
        end
        rst = 1'b1;
        tick();
        tests_run++;
        if (pins !== 11'h000) begin
            tests_failed++;
            $display("FAIL mid_pins: got %h, required 000", pins);
        end
        addr = A_STAT;
        #1;
        tests_run++;
        if (rd !== 16'h0001) begin
            tests_failed++;
            $display("FAIL mid_status: got %h, required 0001", rd);
        end
        addr = '0;
        rst  = 1'b0;
        tick();
        clear_mon();
        wait_idle(400, "mid");
        tests_run++;
        if (rise_q.size() !== 4) begin
            tests_failed++;
            $display("FAIL mid_count: rises=%0d, required 4 (FIFO not flushed)", rise_q.size());
        end else begin
            tests_run++;
            if (rise_q[0] !== 9'h038 || rise_q[3] !== 9'h001) begin
                tests_failed++;
                $display("FAIL mid_restart: got %h..%h, required 038..001", rise_q[0], rise_q[3]);
            end
        end
    endtask

    task automatic test_read();
        logic [31:0] addrs [3];
        addrs = '{A_DATA, 32'h0000_1234, A_STAT};
        re = 1'b1;
        for (int i = 0; i < 3; i++) begin
            addr = addrs[i];
            #1;
            tests_run++;
            if (rd !== 16'h0000) begin
                tests_failed++;
                $display("FAIL read_%h: got %h, required 0000", addrs[i], rd);
            end
        end
        re   = 1'b0;
        addr = '0;
    endtask

    initial begin
        clk           = 1'b0;
        rst           = 1'b1;
        addr          = '0;
        wr_data       = '0;
        we            = 1'b0;
        re            = 1'b0;
        tests_run     = 0;
        tests_failed  = 0;
        cyc           = 0;
        e_prev        = 1'b0;
        busy_prev     = 1'b0;
        prev9         = '0;
        glitch_cnt    = 0;
        busy_fall_cyc = -1;
        tick();
        test_reset();
        test_char();
        test_long_cmd();
        test_overflow();
        test_reset_mid();
        test_read();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/lcd_sequencer.md
Name: lcd_sequencer

Overview:
Memory-mapped HD44780 LCD controller that replaces software bit-banging of the LCD pins. CPU writes to 0xF000 (character) and 0xF001 (command) are queued in a small FIFO. An FSM then generates correctly timed RS/RW/E/data cycles, and after reset it runs the power-on init sequence first. The block sits beside the RAM bus decoder, on the same addr/write/we/re signals; its read data is muxed into the RAM read path.

Parameters:
FIFO_DEPTH, 4, queue entries (power of 2, >=2)
T_SETUP, 2, cycles RS/data are stable before E rises
T_PULSE, 12, cycles E is high
T_HOLD, 2, cycles RS/data are held after E falls
T_SHORT, 2000, post-write wait for data and ordinary commands (40 us @ 50 MHz)
T_LONG, 82000, post-write wait for clear/home commands (1.64 ms)
T_POWERUP, 750000, wait after reset before the first init command (15 ms)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
addr  in  32  bus address
write  in  16  bus write data
we  in  1  write enable
re  in  1  read enable (no side effects; decode only)
read  out  16  read data, combinational from addr
lcdPins  out  11  {E[10], RW[9], RS[8], DATA[7:0]}
busy  out  1  high while the FSM is not idle, FIFO is non-empty, or init is incomplete

Behaviour:
- Reset: the next clk edge sets lcdPins=0, clears the FIFO and the overflow flag, and enters INIT_WAIT with the counter at 0. busy=1. Reset mid-transaction aborts it immediately, and E drops on that edge.
- Bus writes (we=1):
  - 0xF000: push {RS=1, write[7:0]}.
  - 0xF001: push {RS=0, write[7:0]}.
  - 0xF002: clear overflow; write data is ignored.
- A push is accepted iff count<FIFO_DEPTH, sampled before any same-cycle pop. Otherwise the entry is dropped and overflow is set (sticky).
- Pushes are accepted in every FSM state, including during init.
- Read: addr==0xF002 gives {13'b0, overflow, full, busy}. Every other address gives 0.
- RW is always 0.
- FSM states: INIT_WAIT, INIT_LOAD, IDLE, SETUP, PULSE, HOLD, WAIT.
  - INIT_WAIT: count T_POWERUP cycles, then go to INIT_LOAD.
  - INIT_LOAD: take the next entry from the internal 4-entry init ROM (0x38, 0x0C, 0x06, 0x01, all RS=0) and go to SETUP. After the 4th entry's WAIT completes, init_done=1 and the FSM goes to IDLE.
  - IDLE: if the FIFO is non-empty, pop the head into the latched {RS, DATA} and go to SETUP. Otherwise stay.
  - SETUP: drive RS/DATA with E=0 for T_SETUP cycles.
  - PULSE: E=1 for T_PULSE cycles.
  - HOLD: E=0 with RS/DATA held, for T_HOLD cycles.
  - WAIT: count T_LONG if RS=0 and DATA[7:2]==0, else T_SHORT. Then go to INIT_LOAD if init is not done, else IDLE.
- Transaction period, from IDLE pop to next IDLE = 1+T_SETUP+T_PULSE+T_HOLD+Twait cycles.
- RS/DATA keep their last values in IDLE and WAIT; they are never glitched while E=1.
- Counter: a single down-counter, width $clog2(max param + 1). It is loaded with N-1 on state entry; the state exits when the counter is 0. No wrap-around is possible.
- FIFO pointers are log2(FIFO_DEPTH) bits, with natural wrap; count is an extra bit wide. full = (count==FIFO_DEPTH).

Decomposition:
- Package lcd_pkg holds:
  - address constants LCD_DATA_ADDR=0xF000, LCD_CMD_ADDR=0xF001, LCD_STAT_ADDR=0xF002;
  - the FSM state enum;
  - the init ROM constant array;
  - the entry typedef {rs, data[7:0]}.
- One sub-module, lcd_fifo: a synchronous FIFO with push/pop/full/empty/count.

Test Plan:
Bench parameters for all scenarios: T_SETUP=1, T_PULSE=3, T_HOLD=1, T_SHORT=5, T_LONG=20, T_POWERUP=10, FIFO_DEPTH=4.
- Reset, then idle bus: E first rises 11 cycles after reset release with DATA=0x38, RS=0. The four init bytes 0x38/0x0C/0x06/0x01 appear in order, and the 0x01 wait lasts 20 cycles. busy falls after that.
- After init, write 0x41 to 0xF000: E is high for exactly 3 cycles with RS=1, DATA=0x41, and RS/DATA are stable from 1 cycle before E rises to 1 cycle after E falls. busy=0 exactly 11 cycles after the pop.
- Write 0x01 to 0xF001, then 0x42 to 0xF000: the gap from E-fall of 0x01 to the next pop covers HOLD (1) + WAIT (20) cycles.
- During init, write 5 bytes back-to-back: the first 4 are queued and the 5th is dropped. Status reads 0b111; all 4 bytes are output after init. A write to 0xF002 clears bit 2.
- Assert rst while E=1: on the next edge E=0, lcdPins=0 and the FIFO is empty, then the init sequence restarts from 0x38.
- Read addr 0xF000 and 0x1234 → read=0x0000. Read 0xF002 while idle with the FIFO empty → 0x0000.
